// File: rtl/sa_pkg.sv
// sa_pkg: FSM state codes and width helpers shared by sa_mm_core and sa_mac_pe
package sa_pkg;
    typedef enum logic [1:0] {S_IDLE, S_FEED, S_FLUSH, S_DRAIN} state_t;
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
    function automatic int max2(input int a, input int b);
        return a > b ? a : b;
    endfunction
endpackage

// File: rtl/sa_mac_pe.sv
// sa_mac_pe: one systolic PE, forwards operands east/south and accumulates a*b each cycle
// SA_MM_SAT_EN defined: accumulator saturates; undefined: wraps modulo 2^OUT_LEN
module sa_mac_pe import sa_pkg::*; #(
    parameter int IN_LEN  = 8,
    parameter int OUT_LEN = 20
) (
    input  logic                      clk,
    input  logic                      sys_rst,
    input  logic                      clr,
    input  logic signed [IN_LEN-1:0]  a_in,
    input  logic signed [IN_LEN-1:0]  b_in,
    output logic signed [IN_LEN-1:0]  a_out,
    output logic signed [IN_LEN-1:0]  b_out,
    output logic signed [OUT_LEN-1:0] acc
);
    localparam int W = max2(OUT_LEN, 2*IN_LEN) + 1;
`ifdef SA_MM_SAT_EN
    localparam logic signed [W-1:0] HI = {{(W-OUT_LEN+1){1'b0}}, {(OUT_LEN-1){1'b1}}};
    localparam logic signed [W-1:0] LO = ~HI;
`endif
    logic signed [IN_LEN-1:0]   a_q, a_d, b_q, b_d;
    logic signed [OUT_LEN-1:0]  acc_q, acc_d;
    logic signed [2*IN_LEN-1:0] prod;
    logic signed [W-1:0]        acc_w, prod_w, sum;
    always_comb begin
        a_d    = a_in;
        b_d    = b_in;
        prod   = a_in * b_in;
        acc_w  = acc_q;
        prod_w = prod;
        sum    = acc_w + prod_w;
`ifdef SA_MM_SAT_EN
        acc_d  = sum > HI ? OUT_LEN'(HI) : sum < LO ? OUT_LEN'(LO) : OUT_LEN'(sum);
`else
        acc_d  = OUT_LEN'(sum);
`endif
        if (clr) acc_d = '0;
    end
    always_ff @(posedge clk) begin
        if (sys_rst) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            acc_q <= acc_d;
        end
    end
    assign a_out = a_q;
    assign b_out = b_q;
    assign acc   = acc_q;
endmodule

// File: rtl/sa_mm_core.sv
// sa_mm_core: X*Y output-stationary systolic array computing C = A*B with streamed A columns / B rows
// SA_MM_SAT_EN selects saturating accumulation in every PE
module sa_mm_core import sa_pkg::*; #(
    parameter int X       = 3,
    parameter int Y       = 3,
    parameter int N_MAX   = 8,
    parameter int IN_LEN  = 8,
    parameter int OUT_LEN = 20
) (
    input  logic                         clk,
    input  logic                         sys_rst,
    input  logic                         start,
    input  logic [clog2(N_MAX+1)-1:0]    n_len,
    input  logic                         a_val,
    output logic                         a_rdy,
    input  logic [X*IN_LEN-1:0]          a_data,
    input  logic                         b_val,
    output logic                         b_rdy,
    input  logic [Y*IN_LEN-1:0]          b_data,
    output logic                         out_val,
    input  logic                         out_rdy,
    output logic [Y*OUT_LEN-1:0]         out_data,
    output logic [clog2(X):0]            out_row,
    output logic                         busy,
    output logic                         done
);
    localparam int NW = clog2(N_MAX+1);
    localparam int RW = clog2(X) + 1;
    localparam int FW = clog2(X+Y);
    state_t            state_q, state_d;
    logic [NW-1:0]     k_q, k_d, cnt_q, cnt_d;
    logic [FW-1:0]     fl_q, fl_d;
    logic [RW-1:0]     row_q, row_d;
    logic              done_q, done_d, accept, clr, unused_edge;
    logic signed [IN_LEN-1:0]  a_h [X][Y+1];
    logic signed [IN_LEN-1:0]  b_v [X+1][Y];
    logic signed [OUT_LEN-1:0] acc [X][Y];
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        fl_d    = fl_q;
        row_d   = row_q;
        done_d  = 1'b0;
        clr     = 1'b0;
        accept  = state_q == S_FEED && a_val && b_val;
        case (state_q)
            S_IDLE: if (start) begin
                clr     = 1'b1;
                k_d     = n_len > NW'(N_MAX) ? NW'(N_MAX) : n_len;
                cnt_d   = '0;
                fl_d    = '0;
                state_d = k_d == '0 ? S_FLUSH : S_FEED;
            end
            S_FEED: if (accept) begin
                cnt_d   = cnt_q + 1'b1;
                state_d = cnt_d == k_q ? S_FLUSH : S_FEED;
            end
            S_FLUSH: begin
                fl_d    = fl_q + 1'b1;
                state_d = fl_q == FW'(X+Y-2) ? S_DRAIN : S_FLUSH;
            end
            S_DRAIN: if (out_rdy) begin
                done_d  = row_q == RW'(X);
                row_d   = done_d ? RW'(1) : row_q + 1'b1;
                state_d = done_d ? S_IDLE : S_DRAIN;
            end
            default: state_d = S_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (sys_rst) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            cnt_q   <= '0;
            fl_q    <= '0;
            row_q   <= RW'(1);
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            fl_q    <= fl_d;
            row_q   <= row_d;
            done_q  <= done_d;
        end
    end
    assign a_rdy   = state_q == S_FEED && b_val;
    assign b_rdy   = state_q == S_FEED && a_val;
    assign out_val = state_q == S_DRAIN;
    assign busy    = state_q != S_IDLE;
    assign done    = done_q;
    assign out_row = row_q;
    // Lane i is delayed i+1 cycles; zeros are injected whenever no beat is taken so skew never slips
    for (genvar i = 0; i < X; i++) begin : g_ska
        logic signed [IN_LEN-1:0] sr_q [i+1], sr_d [i+1];
        always_comb begin
            sr_d[0] = accept ? a_data[i*IN_LEN +: IN_LEN] : '0;
            for (int d = 1; d <= i; d++) sr_d[d] = sr_q[d-1];
        end
        always_ff @(posedge clk)
            for (int d = 0; d <= i; d++) sr_q[d] <= sys_rst ? '0 : sr_d[d];
        assign a_h[i][0] = sr_q[i];
    end
    for (genvar j = 0; j < Y; j++) begin : g_skb
        logic signed [IN_LEN-1:0] sr_q [j+1], sr_d [j+1];
        always_comb begin
            sr_d[0] = accept ? b_data[j*IN_LEN +: IN_LEN] : '0;
            for (int d = 1; d <= j; d++) sr_d[d] = sr_q[d-1];
        end
        always_ff @(posedge clk)
            for (int d = 0; d <= j; d++) sr_q[d] <= sys_rst ? '0 : sr_d[d];
        assign b_v[0][j] = sr_q[j];
    end
    for (genvar i = 0; i < X; i++) begin : g_row
        for (genvar j = 0; j < Y; j++) begin : g_col
            sa_mac_pe #(.IN_LEN(IN_LEN), .OUT_LEN(OUT_LEN)) u_pe (
                .clk    (clk),
                .sys_rst(sys_rst),
                .clr    (clr),
                .a_in   (a_h[i][j]),
                .b_in   (b_v[i][j]),
                .a_out  (a_h[i][j+1]),
                .b_out  (b_v[i+1][j]),
                .acc    (acc[i][j])
            );
        end
    end
    always_comb begin
        unused_edge = 1'b0;
        for (int i = 0; i < X; i++) unused_edge ^= ^a_h[i][Y];
        for (int j = 0; j < Y; j++) unused_edge ^= ^b_v[X][j];
    end
    always_comb begin
        out_data = '0;
        for (int i = 0; i < X; i++)
            for (int j = 0; j < Y; j++)
                if (out_val && row_q == RW'(i+1)) out_data[j*OUT_LEN +: OUT_LEN] = acc[i][j];
    end
endmodule

// File: tb/tb_sa_mm_core.sv
// tb_sa_mm_core: directed self-checking bench for sa_mm_core (X=Y=3, N_MAX=8, IN_LEN=8, OUT_LEN=20)
module tb_sa_mm_core;
    localparam int X = 3, Y = 3, N_MAX = 8, IL = 8, OL = 20;
    logic clk = 1'b0;
    logic sys_rst, start, a_val, b_val, out_rdy;
    logic [3:0] n_len;
    logic [X*IL-1:0] a_data;
    logic [Y*IL-1:0] b_data;
    logic a_rdy, b_rdy, out_val, busy, done;
    logic [Y*OL-1:0] out_data;
    logic [2:0] out_row;
    int n_chk = 0, n_fail = 0, rdy_seen;
    int A [X][N_MAX];
    int B [N_MAX][Y];

    always #5 clk = ~clk;

    sa_mm_core #(.X(X), .Y(Y), .N_MAX(N_MAX), .IN_LEN(IL), .OUT_LEN(OL)) dut (
        .clk(clk), .sys_rst(sys_rst), .start(start), .n_len(n_len),
        .a_val(a_val), .a_rdy(a_rdy), .a_data(a_data),
        .b_val(b_val), .b_rdy(b_rdy), .b_data(b_data),
        .out_val(out_val), .out_rdy(out_rdy), .out_data(out_data), .out_row(out_row),
        .busy(busy), .done(done)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint expc(input int i, input int j, input int k);
        longint s;
        logic signed [OL-1:0] w;
        s = 0;
        for (int t = 0; t < k; t++) s += longint'(A[i][t]) * longint'(B[t][j]);
`ifdef SA_MM_SAT_EN
        if (s > 524287) s = 524287;
        if (s < -524288) s = -524288;
        return s;
`else
        w = OL'(s);
        return w;
`endif
    endfunction

    task automatic fill(input int av, input int bv);
        for (int i = 0; i < X; i++) for (int t = 0; t < N_MAX; t++) A[i][t] = av;
        for (int t = 0; t < N_MAX; t++) for (int j = 0; j < Y; j++) B[t][j] = bv;
    endtask

    task automatic start_job(input int n);
        n_len = 4'(n);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("start_busy", busy, 1);
    endtask

    task automatic feed(input int k, input bit tog);
        int t, cyc;
        t = 0;
        cyc = 0;
        while (t < k && cyc < 200) begin
            for (int i = 0; i < X; i++) a_data[i*IL +: IL] = IL'(A[i][t]);
            for (int j = 0; j < Y; j++) b_data[j*IL +: IL] = IL'(B[t][j]);
            a_val = tog ? (cyc % 2 == 0) : 1'b1;
            b_val = 1'b1;
            #1;
            if (a_val && b_val && a_rdy && b_rdy) t++;
            @(posedge clk);
            #1;
            cyc++;
        end
        a_val = 1'b0;
        b_val = 1'b0;
        chk("feed_beats", t, k);
    endtask

    task automatic wait_out();
        int c;
        c = 0;
        rdy_seen = 0;
        while (!out_val && c < 100) begin
            if (a_rdy) rdy_seen = 1;
            step();
            c++;
        end
        chk("out_val_wait", out_val, 1);
    endtask

    task automatic drain(input int k, input int stall, input bit hold_start);
        start = hold_start;
        n_len = 4'd1;
        for (int r = 1; r <= X; r++) begin
            wait_out();
            for (int s = 0; s <= stall; s++) begin
                chk($sformatf("row%0d_idx", r), out_row, r);
                for (int j = 0; j < Y; j++)
                    chk($sformatf("row%0d_lane%0d", r, j), $signed(out_data[j*OL +: OL]), expc(r-1, j, k));
                if (s == stall) begin
                    out_rdy = 1'b1;
                    if (r == X) start = 1'b0;
                end
                step();
                out_rdy = 1'b0;
            end
            chk($sformatf("done_after_row%0d", r), done, (r == X) ? 1 : 0);
        end
        chk("idle_after_drain", busy, 0);
        chk("out_val_after_drain", out_val, 0);
        step();
        chk("done_pulse_width", done, 0);
    endtask

    initial begin
        int seen;
        sys_rst = 1'b1; start = 1'b0; n_len = '0; a_val = 1'b1; b_val = 1'b1; out_rdy = 1'b1;
        a_data = '0; b_data = '0;
        step();
        step();
        chk("rst_a_rdy", a_rdy, 0);
        chk("rst_b_rdy", b_rdy, 0);
        chk("rst_out_val", out_val, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_out_row", out_row, 1);
        chk("rst_out_data", out_data, 0);
        a_val = 1'b0; b_val = 1'b0; out_rdy = 1'b0; sys_rst = 1'b0;
        step();

        // identity times B returns B
        fill(0, 0);
        for (int i = 0; i < X; i++) A[i][i] = 1;
        for (int t = 0; t < 3; t++) for (int j = 0; j < Y; j++) B[t][j] = 3*t + j + 1;
        start_job(3);
        feed(3, 1'b0);
        wait_out();
        chk("id_c12_hand", $signed(out_data[OL +: OL]), 2);
        drain(3, 0, 1'b0);

        // toggling a_val and output back-pressure
        fill(2, 2);
        start_job(4);
        feed(4, 1'b1);
        wait_out();
        chk("tog_c11_hand", $signed(out_data[0 +: OL]), 16);
        drain(4, 5, 1'b0);

        // zero-length job
        a_val = 1'b1; b_val = 1'b1;
        start_job(0);
        wait_out();
        chk("n0_a_rdy_never", rdy_seen, 0);
        a_val = 1'b0; b_val = 1'b0;
        drain(0, 0, 1'b0);

        // n_len above N_MAX clamps to 8; extreme operands
        fill(-128, -128);
        start_job(12);
        feed(8, 1'b0);
        wait_out();
        chk("k8_c11_hand", $signed(out_data[0 +: OL]), 131072);
        drain(8, 0, 1'b0);

        // reset in the middle of FLUSH, then a clean job
        fill(5, 5);
        start_job(2);
        feed(2, 1'b0);
        step();
        sys_rst = 1'b1;
        step();
        chk("midrst_busy", busy, 0);
        chk("midrst_out_val", out_val, 0);
        chk("midrst_out_row", out_row, 1);
        chk("midrst_done", done, 0);
        sys_rst = 1'b0;
        step();
        fill(1, 1);
        start_job(2);
        feed(2, 1'b0);
        wait_out();
        chk("after_rst_c11_hand", $signed(out_data[0 +: OL]), 2);
        drain(2, 0, 1'b0);

        // start held high throughout DRAIN is ignored
        fill(0, 0);
        for (int i = 0; i < X; i++) A[i][0] = i + 1;
        for (int j = 0; j < Y; j++) B[0][j] = 1;
        start_job(1);
        feed(1, 1'b0);
        wait_out();
        drain(1, 2, 1'b1);
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            if (busy || out_val) seen = 1;
            step();
        end
        chk("no_second_job", seen, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
